// File: rtl/fa_bist_pkg.sv
// Shared types and constants for the full-adder BIST checker.
package fa_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int         NUM_VECTORS = 8;
    localparam logic [2:0] LAST_VEC    = 3'(NUM_VECTORS - 1);

endpackage

// File: rtl/fa_golden.sv
// Reference full adder: the expected response for the vector being applied.
module fa_golden (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_exp,
    output logic carry_exp
);

    assign sum_exp   = a ^ b ^ cin;
    assign carry_exp = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_bist_checker.sv
// Exhaustive full-adder self-test: applies all 8 input vectors, holds each
// for SETTLE_CYCLES, samples the DUT once and records mismatch statistics.
module fa_bist_checker
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       fa_a,
    output logic       fa_b,
    output logic       fa_cin,
    input  logic       fa_sum,
    input  logic       fa_carry,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] first_fail_vec,
    output state_t     state_dbg
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] err_q, err_d;
    logic       fail_valid_q, fail_valid_d;
    logic [2:0] first_fail_q, first_fail_d;

    logic sum_exp, carry_exp;
    logic mismatch;

    fa_golden u_golden (
        .a         (vec_q[2]),
        .b         (vec_q[1]),
        .cin       (vec_q[0]),
        .sum_exp   (sum_exp),
        .carry_exp (carry_exp)
    );

    assign mismatch = (fa_sum != sum_exp) || (fa_carry != carry_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_q     <= 4'd0;
            vec_q        <= 3'd0;
            err_q        <= 4'd0;
            fail_valid_q <= 1'b0;
            first_fail_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            vec_q        <= vec_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        vec_d        = vec_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        case (state_q)
            IDLE, DONE: begin
                // A start in DONE restarts exactly like one in IDLE.
                if (start) begin
                    state_d      = APPLY;
                    settle_d     = 4'd0;
                    vec_d        = 3'd0;
                    err_d        = 4'd0;
                    fail_valid_d = 1'b0;
                    first_fail_d = 3'd0;
                end
            end
            APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = SAMPLE;
                    settle_d = 4'd0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 4'd1;
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = vec_q;
                    end
                end
                // vec stays at the last index in DONE so the stimulus holds.
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fa_a           = (state_q != IDLE) && vec_q[2];
    assign fa_b           = (state_q != IDLE) && vec_q[1];
    assign fa_cin         = (state_q != IDLE) && vec_q[0];
    assign busy           = (state_q == APPLY) || (state_q == SAMPLE);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == 4'd0);
    assign err_count      = err_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_vec = first_fail_q;
    assign state_dbg      = state_q;

endmodule

// File: doc/fa_bist_checker.md
FA_BIST_CHECKER -- requirements
Module: fa_bist_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the number of cycles each vector is held before sampling; legal range is 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle request to run the exhaustive check.
REQ-005 The block SHALL have ports fa_a, fa_b, fa_cin, each output, 1 bit: stimulus driven to the full-adder DUT.
REQ-006 The block SHALL have ports fa_sum, fa_carry, each input, 1 bit: response sampled from the DUT.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: high from run completion until the next accepted start or reset.
REQ-009 The block SHALL have port pass, output, 1 bit: valid while done is high; 1 means zero mismatches.
REQ-010 The block SHALL have port err_count, output, 4 bits: number of mismatching vectors in the current or last run (0..8).
REQ-011 The block SHALL have port fail_valid, output, 1 bit: high once at least one mismatch has been recorded in the run.
REQ-012 The block SHALL have port first_fail_vec, output, 3 bits: index of the first mismatching vector; meaningful only when fail_valid is high.

Function
REQ-013 Vector index v SHALL count 0..7, mapped as {fa_a, fa_b, fa_cin} = v[2:0] (fa_a is the MSB).
REQ-014 Expected outputs SHALL be sum_exp = a^b^cin and carry_exp = majority(a,b,cin).
REQ-015 The FSM SHALL have states IDLE, APPLY, SAMPLE, DONE.
REQ-016 IDLE->APPLY on start=1: v cleared to 0, err_count and fail_valid cleared, done cleared.
REQ-017 APPLY SHALL last exactly SETTLE_CYCLES cycles with the stimulus for v held stable, then move to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle; at its closing edge fa_sum/fa_carry are compared to expected, and any bit mismatch increments err_count.
REQ-019 On the first mismatch of a run, first_fail_vec SHALL be set to v and fail_valid set; later mismatches SHALL leave first_fail_vec unchanged.
REQ-020 SAMPLE->APPLY with v+1 when v<7; SAMPLE->DONE when v=7, with no wrap of v.
REQ-021 Total run length SHALL be 8*(SETTLE_CYCLES+1) cycles from the start edge to done rising (24 at default).
REQ-022 busy SHALL be high exactly in APPLY and SAMPLE.
REQ-023 pass SHALL equal (err_count==0) while done=1, and SHALL be 0 otherwise.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 start in DONE SHALL be accepted exactly as in IDLE, restarting the run and clearing results.
REQ-026 Stimulus outputs SHALL be 0 in IDLE and SHALL hold the vector-7 value in DONE.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, v=0, all outputs 0 (fa_a, fa_b, fa_cin, busy, done, pass, err_count, fail_valid, first_fail_vec), regardless of clock.
REQ-028 Reset asserted mid-run SHALL abort the run with no partial results retained; the first start after rst deasserts begins a fresh run.

Structure
REQ-029 Package fa_bist_pkg SHALL hold the state_t enum (IDLE, APPLY, SAMPLE, DONE) and the constant NUM_VECTORS=8.
REQ-030 The expected-value computation SHALL be one combinational sub-module, fa_golden (inputs a,b,cin; outputs sum_exp, carry_exp), instantiated once.
REQ-031 A settle counter of 4 bits and a vector counter of 3 bits SHALL be the only counters.

Verification
REQ-032 Correct full adder, default parameter, start pulse -> done rises 24 cycles later; pass=1, err_count=0, fail_valid=0.
REQ-033 DUT with carry stuck-at-0 -> mismatches at v=3,5,6,7; err_count=4, first_fail_vec=3, pass=0.
REQ-034 DUT with sum inverted -> err_count=8, first_fail_vec=0, fail_valid=1.
REQ-035 rst asserted while v=4 in APPLY -> all outputs 0 at once; next start with a correct DUT -> pass=1 after 24 cycles.
REQ-036 start re-pulsed while busy -> run length unchanged at 24 cycles; start in DONE -> err_count cleared, new run of 24 cycles.
REQ-037 SETTLE_CYCLES=1, correct DUT -> done rises 16 cycles after start, pass=1.
